// File: rtl/pow2_lanes.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pow2_lanes
// Brief    : Multi-lane 2^(x-max) unit (2^f ~ 1+f) with a three-stage
//            elastic pipeline and a saturating per-vector lane sum.
// Revision : 1.0 - initial release
// ============================================================================
module pow2_lanes #(
    parameter int LANES     = 4,
    parameter int DATA_SIZE = 8,
    parameter int FRAC      = 4,
    parameter int OUT_W     = 12,
    parameter int SUM_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_SIZE-1:0]   in_x,
    input  logic [DATA_SIZE-1:0]         in_max,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_W-1:0]       out_pow,
    output logic                         out_last,
    output logic                         sum_valid,
    output logic [SUM_W-1:0]             sum_out
);

    localparam int c_d_w = DATA_SIZE + 1;
    localparam int c_i_w = c_d_w - FRAC;
    localparam int c_m_w = FRAC + 1;
    localparam int c_t_w = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + $clog2(LANES) + 1;
    localparam logic [31:0] c_sat_shift = 32'(OUT_W - FRAC);

    logic [LANES*c_d_w-1:0]  w_d;
    logic [LANES*c_i_w-1:0]  w_i;
    logic [LANES*c_m_w-1:0]  w_mant;
    logic [LANES*OUT_W-1:0]  w_r_flat;

    logic [LANES*c_d_w-1:0]  r_s1_d;
    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic [LANES*c_i_w-1:0]  r_s2_i;
    logic [LANES*c_m_w-1:0]  r_s2_mant;
    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic [LANES*OUT_W-1:0]  r_out_pow;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [SUM_W-1:0]        r_acc;

    logic                    w_ld1;
    logic                    w_ld2;
    logic                    w_ld3;
    logic [c_t_w-1:0]        w_lane_sum;
    logic [c_t_w-1:0]        w_base;
    logic [c_t_w-1:0]        w_total;
    logic [SUM_W-1:0]        w_acc_next;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_SIZE-1:0] w_xl;
        logic [c_i_w-1:0]     w_si;
        logic [c_m_w-1:0]     w_sm;
        logic [c_i_w-1:0]     w_neg;
        logic [OUT_W-1:0]     w_r;

        // Sign-extend both operands one bit so the difference never overflows.
        assign w_xl = in_x[l*DATA_SIZE +: DATA_SIZE];
        assign w_d[l*c_d_w +: c_d_w] = {w_xl[DATA_SIZE-1], w_xl} - {in_max[DATA_SIZE-1], in_max};

        // The upper bits of d are floor(d / 2^FRAC); the low bits are the fraction.
        assign w_i[l*c_i_w +: c_i_w]    = r_s1_d[l*c_d_w + FRAC +: c_i_w];
        assign w_mant[l*c_m_w +: c_m_w] = {1'b1, r_s1_d[l*c_d_w +: FRAC]};

        assign w_si  = r_s2_i[l*c_i_w +: c_i_w];
        assign w_sm  = r_s2_mant[l*c_m_w +: c_m_w];
        assign w_neg = ~w_si + c_i_w'(1);

        // mant lies in [2^FRAC, 2^(FRAC+1)), so mant<<i overflows exactly when i >= OUT_W-FRAC.
        always_comb begin
            w_r = '0;
            if (!w_si[c_i_w-1]) begin
                if (32'(w_si) >= c_sat_shift) begin
                    w_r = '1;
                end else begin
                    w_r = OUT_W'(w_sm) << w_si;
                end
            end else begin
                w_r = OUT_W'(w_sm >> w_neg);
            end
        end

        assign w_r_flat[l*OUT_W +: OUT_W] = w_r;
    end

    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_sum = w_lane_sum + {{(c_t_w-OUT_W){1'b0}}, w_r_flat[l*OUT_W +: OUT_W]};
        end
        // A held last beat is being handed off whenever stage 3 reloads, so start fresh.
        w_base     = (r_out_valid && r_out_last) ? '0 : {{(c_t_w-SUM_W){1'b0}}, r_acc};
        w_total    = w_base + w_lane_sum;
        w_acc_next = (w_total > {{(c_t_w-SUM_W){1'b0}}, {SUM_W{1'b1}}}) ? '1 : w_total[SUM_W-1:0];
    end

    assign w_ld3    = !r_out_valid || out_ready;
    assign w_ld2    = !r_s2_valid || w_ld3;
    assign w_ld1    = !r_s1_valid || w_ld2;
    assign in_ready = w_ld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_d      <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_i      <= '0;
            r_s2_mant   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_pow   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (w_ld1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_d    <= w_d;
                    r_s1_last <= in_last;
                end
            end
            if (w_ld2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_i    <= w_i;
                    r_s2_mant <= w_mant;
                    r_s2_last <= r_s1_last;
                end
            end
            if (w_ld3) begin
                r_out_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_out_pow  <= w_r_flat;
                    r_out_last <= r_s2_last;
                    r_acc      <= w_acc_next;
                end else if (r_out_valid && r_out_last) begin
                    r_acc <= '0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pow   = r_out_pow;
    assign out_last  = r_out_last;
    assign sum_out   = r_acc;
    assign sum_valid = r_out_valid && r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_pow2_lanes.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pow2_lanes
// Brief    : Randomised self-checking bench for pow2_lanes against an
//            arithmetic reference model and a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pow2_lanes;
    localparam int LANES = 4;
    localparam int DS    = 8;
    localparam int FRAC  = 4;
    localparam int OUT_W = 12;
    localparam int SUM_W = 16;
    localparam int c_sum_max = (1 << SUM_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*DS-1:0]     in_x = '0;
    logic [DS-1:0]           in_max = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [LANES*OUT_W-1:0]  out_pow;
    logic                    out_last;
    logic                    sum_valid;
    logic [SUM_W-1:0]        sum_out;

    pow2_lanes #(.LANES(LANES), .DATA_SIZE(DS), .FRAC(FRAC), .OUT_W(OUT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_max(in_max), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_pow(out_pow), .out_last(out_last), .sum_valid(sum_valid), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*DS-1:0] x;
        logic [DS-1:0]       m;
        bit                  last;
        int                  cyc;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int msum = 0;
    int last_sum = 0;
    int vec_done = 0;
    bit in_rst = 1'b1;
    bit strict_lat = 1'b0;
    bit hold = 1'b0;
    int rdy_mode = 0;
    logic [LANES*OUT_W-1:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    // 2^(x-max) with 2^f ~ 1+f, written as floor(mant * 2^i) on plain integers.
    function automatic int model_pow(logic [DS-1:0] x, logic [DS-1:0] m);
        int d, i, mant;
        longint r;
        d    = int'($signed(x)) - int'($signed(m));
        i    = d >>> FRAC;
        mant = (1 << FRAC) + (d & ((1 << FRAC) - 1));
        if (i >= 0) begin
            r = longint'(mant) << i;
            if (r > longint'((1 << OUT_W) - 1)) r = (1 << OUT_W) - 1;
        end else begin
            r = (-i > 30) ? 0 : longint'(mant >> (-i));
        end
        return int'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        beat_t b;
        int lsum, e, es;
        if (!in_rst) begin
            check("in_ready", in_ready, !(q.size() == 3 && !out_ready));
            check("sum_valid", sum_valid, out_valid && out_last);
            if (hold) begin
                check("stall_valid", out_valid, 1);
                check("stall_pow", out_pow, held);
            end
            hold = out_valid && !out_ready;
            held = out_pow;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    b = q[0];
                    lsum = 0;
                    for (int l = 0; l < LANES; l++) begin
                        e = model_pow(b.x[l*DS +: DS], b.m);
                        lsum += e;
                        check("lane_pow", out_pow[l*OUT_W +: OUT_W], e);
                    end
                    es = msum + lsum;
                    if (es > c_sum_max) es = c_sum_max;
                    check("sum_out", sum_out, es);
                    check("out_last", out_last, b.last);
                    if (strict_lat && out_ready) check("latency", cyc - b.cyc, 3);
                    if (out_ready) begin
                        void'(q.pop_front());
                        msum = b.last ? 0 : es;
                        if (b.last) begin
                            last_sum = int'(sum_out);
                            vec_done++;
                        end
                    end
                end
            end
            if (in_valid && in_ready) q.push_back('{in_x, in_max, in_last, cyc});
        end
    end

    initial begin : rdy_drv
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [LANES*DS-1:0] x, input logic [DS-1:0] m, input bit last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        in_max   = m;
        in_last  = last;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic rand_beat(output logic [LANES*DS-1:0] x, output logic [DS-1:0] m);
        m = DS'($urandom);
        for (int l = 0; l < LANES; l++) begin
            if ($urandom % 4 == 0) x[l*DS +: DS] = DS'($urandom);
            else                   x[l*DS +: DS] = m - DS'($urandom_range(0, 100));
        end
    endtask

    function automatic logic [LANES*DS-1:0] splat(logic [DS-1:0] v);
        return {LANES{v}};
    endfunction

    initial begin : main
        logic [LANES*DS-1:0] x;
        logic [DS-1:0]       m;
        logic [DS-1:0]       dx [6];
        logic [DS-1:0]       dm [6];
        dx = '{8'h15, 8'h00, 8'h70, 8'h7F, 8'h80, 8'h00};
        dm = '{8'h10, 8'h20, 8'h00, 8'h80, 8'h70, 8'h50};

        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_out_pow", out_pow, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sum_out", sum_out, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        check("rst_in_ready", in_ready, 1);

        check("pin_frac", model_pow(8'h15, 8'h10), 12'h015);
        check("pin_quarter", model_pow(8'h00, 8'h20), 12'h004);
        check("pin_shift7", model_pow(8'h70, 8'h00), 12'h800);
        check("pin_sat", model_pow(8'h7F, 8'h80), 12'hFFF);
        check("pin_under", model_pow(8'h80, 8'h70), 12'h000);
        check("pin_im5", model_pow(8'h00, 8'h50), 12'h000);

        for (int k = 0; k < 6; k++) send(splat(dx[k]), dm[k], k == 5);
        drain();

        strict_lat = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rand_beat(x, m);
            send(x, m, k == 19);
        end
        drain();
        strict_lat = 1'b0;

        for (int k = 0; k < 3; k++) send(splat(8'h23), 8'h23, k == 2);
        drain();
        check("sum_3beat", last_sum, 16'h00C0);
        send(splat(8'hE0), 8'hE0, 1'b1);
        drain();
        check("sum_fresh", last_sum, 16'h0040);

        for (int k = 0; k < 20; k++) send(splat(8'h7F), 8'h80, k == 19);
        drain();
        check("sum_saturate", last_sum, 16'hFFFF);

        rdy_mode = 1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
            rand_beat(x, m);
            send(x, m, (k == 199) || ($urandom % 8 == 0));
        end
        drain();

        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) send(splat(8'h40), 8'h40, 1'b0);
        in_rst = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum_valid", sum_valid, 0);
        check("mid_rst_out_pow", out_pow, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_sum_out", sum_out, 0);
        q.delete();
        msum = 0;
        hold = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1);
        for (int k = 0; k < 2; k++) send(splat(8'h11), 8'h11, k == 1);
        drain();
        check("sum_after_rst", last_sum, 16'h0080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
